fifo_apb_adc_mc: RTL and testbench
==================================

# fifo_apb_adc_mc

Multi-channel ADC sample FIFO. It accepts independent write strobes from NUM_CH ADC channels and merges them through a round-robin arbiter into one tagged FIFO. The FIFO is read from the APB peripheral side in first-word-fall-through mode. Next generation of the single-channel ADC FIFO: it adds channel tagging, per-channel overflow detection, a fill level and a programmable watermark flag.

## Interface
- DATA_WIDTH, 56, sample width per channel.
- DEPTH, 16, FIFO entries; power of two, ≥4. AW = clog2(DEPTH).
- NUM_CH, 4, ADC channels; ≥2. CW = clog2(NUM_CH).

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- adc_wr_en  in  NUM_CH  per-channel one-cycle sample strobe.
- adc_data  in  NUM_CH*DATA_WIDTH  channel i sample at bits [i*DATA_WIDTH +: DATA_WIDTH].
- apb_rd_en  in  1  pop the head entry.
- apb_rd_data  out  DATA_WIDTH  head sample (FWFT).
- apb_rd_ch  out  CW  channel tag of the head sample.
- fifo_empty  out  1  no entries.
- fifo_full  out  1  DEPTH entries.
- fifo_level  out  AW+1  entry count, 0..DEPTH.
- wm_level  in  AW+1  watermark threshold.
- fifo_wm  out  1  level ≥ wm_level; forced 0 when wm_level == 0.
- ch_overflow  out  NUM_CH  sticky per-channel sample-drop flags.
- fifo_clear  in  1  synchronous flush.

## Operation
- Each channel has a one-entry holding register (hold_vld[i], hold_data[i]). A strobe on channel i loads hold_data[i] and sets hold_vld[i].
- Strobe while hold_vld[i]=1 and channel i is not drained in the same cycle: the new sample is dropped, the held sample is kept, and ch_overflow[i] is set.
- Strobe in the same cycle that channel i is drained: the new sample is accepted, hold_vld[i] stays 1, and no overflow is flagged.
- Arbiter: round-robin pointer rr (reset 0). When !fifo_full, grant the first i with hold_vld[i]=1, searching rr, rr+1, … mod NUM_CH.
  - The grant writes {i, hold_data[i]} to mem[wr_ptr], clears hold_vld[i] (unless refilled that cycle), and sets rr = (i+1) mod NUM_CH.
  - rr is unchanged when nothing is granted.
  - At most one transfer per cycle.
- Push is blocked when fifo_full=1, even if a pop occurs in the same cycle. The held sample stays and retries the next cycle.
- Pop: apb_rd_en && !fifo_empty advances rd_ptr. apb_rd_en while empty is ignored; no state changes.
- Push and pop in the same cycle leave fifo_level unchanged.
- Pointers are AW bits and wrap DEPTH-1 → 0. Level is AW+1 bits. Full = (level == DEPTH); empty = (level == 0).
- apb_rd_data and apb_rd_ch are combinational from mem[rd_ptr]. Their value is don't-care while empty.
- fifo_clear: zeroes pointers, level, hold_vld, ch_overflow and rr. It has priority over same-cycle strobes, grants and pops; those are discarded. mem contents are not cleared.
- ch_overflow clears only on rst or fifo_clear.
- rst takes priority over fifo_clear and behaves identically, including mid-transfer.

## Timing
Reset values:
- fifo_empty=1, fifo_full=0, fifo_level=0, fifo_wm=0, ch_overflow=0, apb_rd_ch=0, hold_vld=0, rr=0.
- apb_rd_data is undefined.

Latency and status timing:
- Strobe sampled at edge N → hold_vld set after N → FIFO write at edge N+1 (if granted) → fifo_empty=0, fifo_level+1 and head visible after N+1. Minimum strobe-to-readable latency is 2 cycles.
- Contention: with k channels pending, the last one waits up to NUM_CH-1 extra cycles.
- Pop sampled at edge N → next entry on apb_rd_data after N.
- fifo_full, fifo_empty and fifo_wm are derived from the registered level. They update in the cycle after the push/pop edge, with no additional delay.
- fifo_wm tracks wm_level changes combinationally.
- ch_overflow[i] is visible the cycle after the dropping edge.

## Test plan
- Reset / idle: assert rst for 2 cycles → fifo_empty=1, fifo_level=0, ch_overflow=4'b0000; apb_rd_en while empty → no change.
- Single channel: strobe channel 2 with 56'h00_1234_5678_9ABC → after 2 edges fifo_empty=0, apb_rd_data=56'h00123456789ABC, apb_rd_ch=2; one pop → fifo_empty=1.
- Round-robin: strobe all 4 channels in one cycle with data 0x10..0x13 → entries in tag order 0,1,2,3; next round starting with channel 1 pending → rr=0 still grants 1, then rr=2.
- Full and wrap: 20 sequential single-channel writes with no reads → fifo_full=1 at level 16, hold retained, ch_overflow set on the next strobe; then 8 pops and 8 more writes → data in order across the pointer wrap.
- Watermark: wm_level=5 → fifo_wm=0 at level 4, 1 at level 5; wm_level=0 → fifo_wm=0 at any level.
- Clear / collision: fifo_clear at level 7 with a same-cycle strobe and pop → level 0, fifo_empty=1, ch_overflow=0, strobe discarded; push and pop in the same cycle at level 3 → level stays 3.

Source files
------------

// File: rtl/fifo_apb_adc_mc_if.sv
// rtl/fifo_apb_adc_mc_if.sv - ADC strobe / APB read bundle for the multi-channel sample FIFO
interface fifo_apb_adc_mc_if #(
    parameter int DATA_WIDTH = 56,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CH);

    logic [NUM_CH-1:0]            adc_wr_en;
    logic [NUM_CH*DATA_WIDTH-1:0] adc_data;
    logic                         apb_rd_en;
    logic [DATA_WIDTH-1:0]        apb_rd_data;
    logic [CW-1:0]                apb_rd_ch;
    logic                         fifo_empty;
    logic                         fifo_full;
    logic [AW:0]                  fifo_level;
    logic [AW:0]                  wm_level;
    logic                         fifo_wm;
    logic [NUM_CH-1:0]            ch_overflow;
    logic                         fifo_clear;

    modport slave (
        input  adc_wr_en, adc_data, apb_rd_en, wm_level, fifo_clear,
        output apb_rd_data, apb_rd_ch, fifo_empty, fifo_full, fifo_level, fifo_wm, ch_overflow
    );

    modport master (
        output adc_wr_en, adc_data, apb_rd_en, wm_level, fifo_clear,
        input  apb_rd_data, apb_rd_ch, fifo_empty, fifo_full, fifo_level, fifo_wm, ch_overflow
    );
endinterface

// File: rtl/fifo_apb_adc_mc.sv
// rtl/fifo_apb_adc_mc.sv - multi-channel ADC sample FIFO with round-robin merge and FWFT APB read
module fifo_apb_adc_mc #(
    parameter int DATA_WIDTH = 56,
    parameter int DEPTH      = 16,
    parameter int NUM_CH     = 4
) (
    input  logic              clk,
    input  logic              rst,
    fifo_apb_adc_mc_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(NUM_CH);
    localparam int EW = CW + DATA_WIDTH;

    logic [EW-1:0]         mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           level;
    logic [CW-1:0]         rr;
    logic [NUM_CH-1:0]     hold_vld;
    logic [DATA_WIDTH-1:0] hold_data [NUM_CH];
    logic [NUM_CH-1:0]     ch_overflow;
    logic [NUM_CH-1:0]     drain;
    logic                  gnt_vld;
    logic [CW-1:0]         gnt_idx;
    logic                  push;
    logic                  pop;
    logic                  flush;
    logic                  empty;
    logic                  full;
    logic [EW-1:0]         head;

    // NUM_CH need not be a power of two, so the modulo wrap is explicit.
    function automatic logic [CW-1:0] wrap_idx(input logic [CW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_CH)
            s = s - NUM_CH;
        return s[CW-1:0];
    endfunction

    assign empty = (level == '0);
    assign full  = (level == (AW+1)'(DEPTH));
    assign flush = rst || bus.fifo_clear;
    assign pop   = bus.apb_rd_en && !empty;
    assign push  = gnt_vld;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!full) begin
            for (int k = 0; k < NUM_CH; k++) begin
                if (!gnt_vld && hold_vld[wrap_idx(rr, k)]) begin
                    gnt_vld = 1'b1;
                    gnt_idx = wrap_idx(rr, k);
                end
            end
        end
    end

    always_comb begin
        drain = '0;
        if (gnt_vld)
            drain[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            rr          <= '0;
            hold_vld    <= '0;
            ch_overflow <= '0;
        end else begin
            // A strobe landing on the drain cycle refills the slot instead of overflowing.
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.adc_wr_en[i]) begin
                    if (hold_vld[i] && !drain[i])
                        ch_overflow[i] <= 1'b1;
                    else
                        hold_vld[i] <= 1'b1;
                end else if (drain[i]) begin
                    hold_vld[i] <= 1'b0;
                end
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
                rr     <= wrap_idx(gnt_idx, 1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push && !pop)
                level <= level + (AW+1)'(1);
            else if (!push && pop)
                level <= level - (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!flush && bus.adc_wr_en[i] && (!hold_vld[i] || drain[i]))
                hold_data[i] <= bus.adc_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
        if (!flush && push)
            mem[wr_ptr] <= {gnt_idx, hold_data[gnt_idx]};
    end

    assign head            = mem[rd_ptr];
    assign bus.apb_rd_data = head[DATA_WIDTH-1:0];
    assign bus.apb_rd_ch   = empty ? '0 : head[EW-1 -: CW];
    assign bus.fifo_empty  = empty;
    assign bus.fifo_full   = full;
    assign bus.fifo_level  = level;
    assign bus.fifo_wm     = (bus.wm_level != '0) && (level >= bus.wm_level);
    assign bus.ch_overflow = ch_overflow;
endmodule

// File: tb/tb_fifo_apb_adc_mc.sv
// tb/tb_fifo_apb_adc_mc.sv - directed self-checking bench for fifo_apb_adc_mc
module tb_fifo_apb_adc_mc;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    fifo_apb_adc_mc_if #(.DATA_WIDTH(56), .DEPTH(16), .NUM_CH(4)) bus ();

    fifo_apb_adc_mc #(.DATA_WIDTH(56), .DEPTH(16), .NUM_CH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [3:0] m, input logic [55:0] d0, input logic [55:0] d1,
                          input logic [55:0] d2, input logic [55:0] d3);
        bus.adc_wr_en = m;
        bus.adc_data  = {d3, d2, d1, d0};
        tick();
        bus.adc_wr_en = '0;
    endtask

    task automatic pop_one();
        bus.apb_rd_en = 1'b1;
        tick();
        bus.apb_rd_en = 1'b0;
    endtask

    initial begin
        logic [55:0] exp_d;
        total = 0;
        bad   = 0;
        rst            = 1'b1;
        bus.adc_wr_en  = '0;
        bus.adc_data   = '0;
        bus.apb_rd_en  = 1'b0;
        bus.wm_level   = '0;
        bus.fifo_clear = 1'b0;

        // reset / idle
        tick();
        tick();
        check("rst_empty", 64'(bus.fifo_empty), 64'd1);
        check("rst_full", 64'(bus.fifo_full), 64'd0);
        check("rst_level", 64'(bus.fifo_level), 64'd0);
        check("rst_wm", 64'(bus.fifo_wm), 64'd0);
        check("rst_ovf", 64'(bus.ch_overflow), 64'h0);
        check("rst_ch", 64'(bus.apb_rd_ch), 64'd0);
        rst = 1'b0;
        pop_one();
        check("idle_pop_level", 64'(bus.fifo_level), 64'd0);
        check("idle_pop_empty", 64'(bus.fifo_empty), 64'd1);

        // single channel, 2-cycle latency
        strobe(4'b0100, 56'h0, 56'h0, 56'h00_1234_5678_9ABC, 56'h0);
        check("single_lat1_empty", 64'(bus.fifo_empty), 64'd1);
        tick();
        check("single_empty", 64'(bus.fifo_empty), 64'd0);
        check("single_level", 64'(bus.fifo_level), 64'd1);
        check("single_data", 64'(bus.apb_rd_data), 64'h00_1234_5678_9ABC);
        check("single_ch", 64'(bus.apb_rd_ch), 64'd2);
        pop_one();
        check("single_pop_empty", 64'(bus.fifo_empty), 64'd1);

        // round-robin from rr=0
        bus.fifo_clear = 1'b1;
        tick();
        bus.fifo_clear = 1'b0;
        strobe(4'b1111, 56'h10, 56'h11, 56'h12, 56'h13);
        for (int i = 0; i < 4; i++) tick();
        check("rr_level4", 64'(bus.fifo_level), 64'd4);
        for (int i = 0; i < 4; i++) begin
            check("rr_ch", 64'(bus.apb_rd_ch), 64'(i));
            check("rr_data", 64'(bus.apb_rd_data), 64'h10 + 64'(i));
            pop_one();
        end
        strobe(4'b0010, 56'h0, 56'h21, 56'h0, 56'h0);
        tick();
        check("rr_ch1_ch", 64'(bus.apb_rd_ch), 64'd1);
        check("rr_ch1_data", 64'(bus.apb_rd_data), 64'h21);
        pop_one();
        strobe(4'b0101, 56'h30, 56'h0, 56'h32, 56'h0);
        tick();
        tick();
        check("rr2_level", 64'(bus.fifo_level), 64'd2);
        check("rr2_first_ch", 64'(bus.apb_rd_ch), 64'd2);
        check("rr2_first_data", 64'(bus.apb_rd_data), 64'h32);
        pop_one();
        check("rr2_second_ch", 64'(bus.apb_rd_ch), 64'd0);
        check("rr2_second_data", 64'(bus.apb_rd_data), 64'h30);
        pop_one();
        check("rr2_empty", 64'(bus.fifo_empty), 64'd1);

        // full, hold retention, overflow, pointer wrap
        for (int k = 0; k < 20; k++) begin
            bus.adc_wr_en = 4'b0001;
            bus.adc_data  = {168'h0, 56'h100 + 56'(k)};
            tick();
        end
        bus.adc_wr_en = '0;
        check("full_flag", 64'(bus.fifo_full), 64'd1);
        check("full_level", 64'(bus.fifo_level), 64'd16);
        check("full_ovf", 64'(bus.ch_overflow), 64'h1);
        for (int k = 0; k < 8; k++) begin
            check("wrap_pop_data", 64'(bus.apb_rd_data), 64'h100 + 64'(k));
            pop_one();
        end
        check("wrap_level9", 64'(bus.fifo_level), 64'd9);
        for (int k = 0; k < 8; k++) begin
            bus.adc_wr_en = 4'b0001;
            bus.adc_data  = {168'h0, 56'h200 + 56'(k)};
            tick();
        end
        bus.adc_wr_en = '0;
        check("wrap_full", 64'(bus.fifo_full), 64'd1);
        for (int j = 0; j < 17; j++) begin
            if (j < 8)
                exp_d = 56'h108 + 56'(j);
            else if (j == 8)
                exp_d = 56'h110;
            else
                exp_d = 56'h200 + 56'(j - 9);
            check("wrap_read_data", 64'(bus.apb_rd_data), 64'(exp_d));
            pop_one();
        end
        check("wrap_empty", 64'(bus.fifo_empty), 64'd1);

        // watermark
        bus.wm_level = 5'd5;
        strobe(4'b1111, 56'h1, 56'h2, 56'h3, 56'h4);
        for (int i = 0; i < 4; i++) tick();
        check("wm_level4", 64'(bus.fifo_level), 64'd4);
        check("wm_at4", 64'(bus.fifo_wm), 64'd0);
        strobe(4'b0010, 56'h0, 56'h5, 56'h0, 56'h0);
        tick();
        check("wm_level5", 64'(bus.fifo_level), 64'd5);
        check("wm_at5", 64'(bus.fifo_wm), 64'd1);
        bus.wm_level = 5'd0;
        #1;
        check("wm_zero", 64'(bus.fifo_wm), 64'd0);
        bus.wm_level = 5'd5;

        // clear with colliding strobe and pop
        strobe(4'b1100, 56'h0, 56'h0, 56'h6, 56'h7);
        tick();
        tick();
        check("clr_pre_level", 64'(bus.fifo_level), 64'd7);
        check("clr_pre_ovf", 64'(bus.ch_overflow), 64'h1);
        bus.fifo_clear = 1'b1;
        bus.apb_rd_en  = 1'b1;
        strobe(4'b0001, 56'hAA, 56'h0, 56'h0, 56'h0);
        bus.fifo_clear = 1'b0;
        bus.apb_rd_en  = 1'b0;
        check("clr_level", 64'(bus.fifo_level), 64'd0);
        check("clr_empty", 64'(bus.fifo_empty), 64'd1);
        check("clr_ovf", 64'(bus.ch_overflow), 64'h0);
        tick();
        check("clr_strobe_dropped", 64'(bus.fifo_empty), 64'd1);

        // simultaneous push and pop at level 3
        strobe(4'b0111, 56'h40, 56'h41, 56'h42, 56'h0);
        for (int i = 0; i < 3; i++) tick();
        check("pp_level3", 64'(bus.fifo_level), 64'd3);
        strobe(4'b1000, 56'h0, 56'h0, 56'h0, 56'h43);
        pop_one();
        check("pp_level_hold", 64'(bus.fifo_level), 64'd3);
        check("pp_head_ch", 64'(bus.apb_rd_ch), 64'd1);
        check("pp_head_data", 64'(bus.apb_rd_data), 64'h41);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
